mem_bus_requester: RTL and testbench

CPU-side initiator for the shared memory bus; the responder on that bus is the memory controller.
- Accepts one load/store request at a time from the pipeline through a valid/ready handshake.
- Drives the bus address, rw and valid lines and owns the write direction of the tri-state data bus.
- Waits out the controller's fixed access latency, then returns read data or write completion to the pipeline as a one-cycle response pulse.

---
 rtl/mem_bus_requester_pkg.sv | 25 ++
 rtl/mem_bus_requester_if.sv | 27 ++
 rtl/mem_bus_data_driver.sv | 12 +
 rtl/mem_bus_requester.sv | 106 ++++++++++
 tb/tb_mem_bus_requester.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_requester_pkg.sv
// Shared memory-bus types and constants, imported by the requester and the memory controller.
package InstructionStruct;
  localparam int DWIDTH    = 32;
  localparam int CPUAWIDTH = 32;
  localparam int AWIDTH    = 10;
  localparam int MEMDEPTH  = 1 << AWIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_req_state_t;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  function automatic logic misaligned(input logic [CPUAWIDTH-1:0] a);
    return (a & CPUAWIDTH'(3)) != '0;
  endfunction

  function automatic logic [CPUAWIDTH-1:0] word_addr(input logic [CPUAWIDTH-1:0] a);
    return a & ~CPUAWIDTH'(3);
  endfunction
endpackage

// File: rtl/mem_bus_requester_if.sv
// Pipeline handshake plus bus control lines between the pipeline, requester and controller.
interface mem_bus_requester_if;
  import InstructionStruct::*;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rw;
  logic [CPUAWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0]    req_wdata;
  logic                 resp_valid;
  logic [DWIDTH-1:0]    resp_rdata;
  logic                 resp_err;
  logic [CPUAWIDTH-1:0] bus_addr;
  logic                 bus_rw;
  logic                 bus_valid;
  logic                 busy;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_addr, bus_rw, bus_valid, busy
  );
  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_addr, bus_rw, bus_valid, busy
  );
endinterface

// File: rtl/mem_bus_data_driver.sv
// Tri-state driver for the shared data bus: drives data_i when oe_i, else releases; data_o mirrors the bus.
module mem_bus_data_driver
  import InstructionStruct::*;
(
  input  logic              oe_i,
  input  logic [DWIDTH-1:0] data_i,
  inout  wire  [DWIDTH-1:0] bus_io,
  output logic [DWIDTH-1:0] data_o
);
  assign bus_io = oe_i ? data_i : 'z;
  assign data_o = bus_io;
endmodule

// File: rtl/mem_bus_requester.sv
// CPU-side memory bus initiator: IDLE -> ISSUE -> WAIT(LATENCY) -> RESP.
// Define MEM_REQ_ALIGN_CHECK_EN to short-circuit misaligned requests to an error response.
module mem_bus_requester
  import InstructionStruct::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_requester_if.master bus,
  inout  wire  [DWIDTH-1:0]   bus_data
);
  mem_req_state_t       state_q, state_d;
  logic                 rw_q, rw_d;
  logic [CPUAWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0]    wdata_q, wdata_d, rdata_q, bus_rd;
  logic [3:0]           cnt_q, cnt_d;
  logic                 bus_valid_q, resp_valid_q, resp_err_q, resp_err_d, drv_q;
  logic                 accept, bad_align;
  logic [CPUAWIDTH-1:0] cap_addr;

  // req_ready must read 0 while reset is held even though the state already sits in IDLE
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.busy      = (state_q != IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef MEM_REQ_ALIGN_CHECK_EN
  assign bad_align = misaligned(bus.req_addr);
  assign cap_addr  = bus.req_addr;
`else
  assign bad_align = 1'b0;
  assign cap_addr  = word_addr(bus.req_addr);
`endif

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    resp_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        if (bad_align) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else begin
          state_d = ISSUE;
          rw_d    = bus.req_rw;
          addr_d  = cap_addr;
          wdata_d = bus.req_wdata;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rw_q         <= BUS_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      drv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      bus_valid_q  <= (state_d == ISSUE);
      resp_valid_q <= (state_d == RESP);
      resp_err_q   <= resp_err_d;
      // write data is owned from ISSUE through the last WAIT cycle, released in RESP
      drv_q        <= (state_d == ISSUE || state_d == WAIT) && (rw_d == BUS_WRITE);
      if (state_q == WAIT && cnt_q == '0 && rw_q == BUS_READ)
        rdata_q <= bus_rd;
    end
  end

  mem_bus_data_driver u_drv (
    .oe_i   (drv_q),
    .data_i (wdata_q),
    .bus_io (bus_data),
    .data_o (bus_rd)
  );

  assign bus.bus_valid  = bus_valid_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_rw     = rw_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_mem_bus_requester.sv
// Scoreboard bench for mem_bus_requester with a behavioural memory controller on the tri-state bus.
module tb_mem_bus_requester;
  import InstructionStruct::*;
  localparam int          LAT   = 2;
  localparam logic [31:0] PROBE = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  mem_bus_requester_if bif ();
  mem_bus_requester_if bif1 ();
  mem_bus_requester_if bif15 ();
  wire [DWIDTH-1:0] bus_data, bd1, bd15;

  mem_bus_requester #(.LATENCY(LAT)) dut  (.clk(clk), .reset(reset), .bus(bif),   .bus_data(bus_data));
  mem_bus_requester #(.LATENCY(1))   u_l1 (.clk(clk), .reset(reset), .bus(bif1),  .bus_data(bd1));
  mem_bus_requester #(.LATENCY(15))  u_l15(.clk(clk), .reset(reset), .bus(bif15), .bus_data(bd15));

  assign bd1  = 32'hC0FFEE01;
  assign bd15 = 32'hC0FFEE0F;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // behavioural controller: releases the bus during writes, returns mem data during reads, probe otherwise
  logic [31:0] mem [0:63];
  int          hold_cnt;
  logic        hold_rw;
  logic        wr_win, rd_win;
  logic [31:0] tb_val;
  always @(posedge clk or posedge reset)
    if (reset) begin
      hold_cnt <= 0;
      hold_rw  <= 1'b1;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bif.bus_valid) begin
      hold_cnt <= LAT;
      hold_rw  <= bif.bus_rw;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1 && !hold_rw) mem[bif.bus_addr[7:2]] <= bus_data;
    end
  assign wr_win   = (bif.bus_valid && !bif.bus_rw) || (hold_cnt > 0 && !hold_rw);
  assign rd_win   = (bif.bus_valid &&  bif.bus_rw) || (hold_cnt > 0 &&  hold_rw);
  assign tb_val   = rd_win ? mem[bif.bus_addr[7:2]] : PROBE;
  assign bus_data = wr_win ? 'z : tb_val;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          bv;
    int          rc;
  } item_t;
  item_t       sb[$];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic exp_err(input logic [31:0] a);
`ifdef MEM_REQ_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_baddr(input logic [31:0] a);
`ifdef MEM_REQ_ALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  // monitor: compare bus activity and responses against the head of the scoreboard
  initial forever begin
    item_t it;
    logic [31:0] er;
    @(negedge clk);
    if (reset) begin
      sb.delete();
      exp_mem.delete();
      last_rd = '0;
    end else begin
      if (bif.bus_valid) begin
        if (sb.size() == 0) chk("bv_spurious", 1, 0);
        else begin
          chk("bv_cyc",  cyc,          sb[0].bv);
          chk("bv_rw",   bif.bus_rw,   sb[0].rw);
          chk("bv_addr", bif.bus_addr, exp_baddr(sb[0].addr));
        end
      end
      if (sb.size() > 0 && !sb[0].err && cyc > sb[0].bv && cyc <= sb[0].bv + LAT) begin
        chk("wait_addr", bif.bus_addr,  exp_baddr(sb[0].addr));
        chk("wait_rw",   bif.bus_rw,    sb[0].rw);
        chk("wait_bv",   bif.bus_valid, 0);
      end
      if (sb.size() > 0 && !sb[0].err && !sb[0].rw && cyc >= sb[0].bv && cyc <= sb[0].bv + LAT)
        chk("wdata", bus_data, sb[0].wdata);
      if (bif.resp_valid) begin
        if (sb.size() == 0) chk("resp_spurious", 1, 0);
        else begin
          it = sb.pop_front();
          chk("resp_cyc",     cyc,           it.rc);
          chk("resp_err",     bif.resp_err,  it.err);
          chk("resp_ready",   bif.req_ready, 0);
          chk("resp_release", bus_data,      PROBE);
          if (!it.err && it.rw) begin
            er = exp_mem.exists(exp_baddr(it.addr)) ? exp_mem[exp_baddr(it.addr)] : 32'h0;
            last_rd = er;
          end else if (!it.err) exp_mem[exp_baddr(it.addr)] = it.wdata;
          chk("resp_rdata", bif.resp_rdata, last_rd);
        end
      end
    end
  end

  task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int acc);
    int n;
    item_t it;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_rw = rw; bif.req_addr = a; bif.req_wdata = d;
    n = 0;
    while (!bif.req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk("accept_timeout", 0, 1);
      bif.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc      = cyc;
    it.rw    = rw;
    it.addr  = a;
    it.wdata = d;
    it.err   = exp_err(a);
    it.bv    = it.err ? -1 : acc;
    it.rc    = it.err ? acc : acc + 1 + LAT;
    sb.push_back(it);
    if (!hold) begin @(negedge clk); bif.req_valid = 1'b0; end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, a1, a2, r1, r15, bad1, bad15;
    bif.req_valid = 0;   bif.req_rw = 0;   bif.req_addr = '0;   bif.req_wdata = '0;
    bif1.req_valid = 0;  bif1.req_rw = 0;  bif1.req_addr = '0;  bif1.req_wdata = '0;
    bif15.req_valid = 0; bif15.req_rw = 0; bif15.req_addr = '0; bif15.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", bif.req_ready,  0);
    chk("rst_busy",  bif.busy,       0);
    chk("rst_resp",  bif.resp_valid, 0);
    chk("rst_err",   bif.resp_err,   0);
    chk("rst_rdata", bif.resp_rdata, 0);
    chk("rst_bv",    bif.bus_valid,  0);
    chk("rst_rw",    bif.bus_rw,     1);
    chk("rst_addr",  bif.bus_addr,   0);
    chk("rst_data",  bus_data,       PROBE);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_ready", bif.req_ready, 1);

    // write/read round trip
    do_req(1'b0, 32'h10, 32'hDEADBEEF, 0, a);
    drain();
    do_req(1'b1, 32'h10, 32'h0, 0, a);
    drain();

    // reset in the middle of a write's WAIT
    do_req(1'b0, 32'h40, 32'hCAFEF00D, 0, a);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    chk("mid_bv",    bif.bus_valid,  0);
    chk("mid_data",  bus_data,       PROBE);
    chk("mid_resp",  bif.resp_valid, 0);
    chk("mid_rdata", bif.resp_rdata, 0);
    chk("mid_ready", bif.req_ready,  0);
    chk("mid_busy",  bif.busy,       0);
    chk("mid_rw",    bif.bus_rw,     1);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ready", bif.req_ready, 1);
    repeat (6) @(negedge clk);

    // fill memory, then back-to-back reads with req_valid held high
    do_req(1'b0, 32'h10, 32'h12345678, 0, a);
    drain();
    do_req(1'b0, 32'h24, 32'h0A0B0C0D, 0, a);
    drain();
    do_req(1'b1, 32'h20, 32'h0, 1, a1);
    do_req(1'b1, 32'h24, 32'h0, 0, a2);
    chk("b2b_gap", a2 - a1, LAT + 3);
    drain();

    // misaligned read
    do_req(1'b1, 32'h13, 32'h0, 0, a);
    drain();

    // LATENCY=1 and LATENCY=15 instances reading 0x30
    @(negedge clk);
    chk("l1_ready",  bif1.req_ready,  1);
    chk("l15_ready", bif15.req_ready, 1);
    bif1.req_valid = 1;  bif1.req_rw = 1;  bif1.req_addr = 32'h30;
    bif15.req_valid = 1; bif15.req_rw = 1; bif15.req_addr = 32'h30;
    @(posedge clk); #1;
    a = cyc;
    r1 = -1; r15 = -1; bad1 = 0; bad15 = 0;
    @(negedge clk);
    bif1.req_valid = 0; bif15.req_valid = 0;
    chk("l1_bv",  bif1.bus_valid,  1);
    chk("l15_bv", bif15.bus_valid, 1);
    for (int i = 0; i < 25; i++) begin
      if (bif1.resp_valid && r1 < 0) begin
        r1 = cyc;
        chk("l1_rdata", bif1.resp_rdata, 32'hC0FFEE01);
      end
      if (bif15.resp_valid && r15 < 0) begin
        r15 = cyc;
        chk("l15_rdata", bif15.resp_rdata, 32'hC0FFEE0F);
      end
      if (r1 < 0 && bif1.bus_addr != 32'h30) bad1++;
      if (r15 < 0 && bif15.bus_addr != 32'h30) bad15++;
      @(negedge clk);
    end
    chk("l1_resp_cyc",     r1,    a + 2);
    chk("l15_resp_cyc",    r15,   a + 16);
    chk("l1_addr_stable",  bad1,  0);
    chk("l15_addr_stable", bad15, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
